// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port data memory between two requesters:
//   r0 = core memory-access stage, r1 = debug/DMA port.
// One access is in flight at a time. A request is accepted with a
// combinational grant in IDLE, the access is issued to memory with registered
// strobes one cycle later, and read data comes back to the owner as a
// registered one-cycle rvalid pulse.
//
// Parameters
//   ADDR_W  address width
//   DATA_W  data width
//   RD_LAT  memory read latency (1..4): mem_rdata_i is valid RD_LAT cycles
//           after the cycle mem_re_o is high
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   rN_req_i/we_i/addr_i/wdata_i requester N command (held until granted)
//   rN_gnt_o                     request accepted this cycle
//   rN_rvalid_o, rN_rdata_o      read return for requester N
//   mem_re_o, mem_we_o           registered memory strobes
//   mem_addr_o, mem_wdata_o      registered memory address / write data
//   mem_rdata_i                  memory read data
//
// Configuration macro
//   DMEM_ARB_FIXED_PRIO_EN  defined: r0 always wins contention.
//                           undefined: round-robin between the two ports.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req_i,
  input  logic              r0_we_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [DATA_W-1:0] r0_wdata_i,
  output logic              r0_gnt_o,
  output logic              r0_rvalid_o,
  output logic [DATA_W-1:0] r0_rdata_o,
  input  logic              r1_req_i,
  input  logic              r1_we_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [DATA_W-1:0] r1_wdata_i,
  output logic              r1_gnt_o,
  output logic              r1_rvalid_o,
  output logic [DATA_W-1:0] r1_rdata_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

  state_t            state;
  state_t            next_state;
  logic [2:0]        lat_cnt;
  logic              owner;
  logic              grant_any;
  logic              grant_sel;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              rd_done;

`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic              last_winner;
`endif

  // Next-state and grant decode. Grants are gated with rst_n so they drop
  // immediately when reset is asserted, even though the state is already IDLE.
  always_comb begin
    next_state = state;
    grant_any  = 1'b0;
    grant_sel  = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && (r0_req_i || r1_req_i)) begin
          grant_any  = 1'b1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
          grant_sel  = !r0_req_i;
`else
          // Under contention the port that did not win last time goes next.
          grant_sel  = (r0_req_i && r1_req_i) ? !last_winner : !r0_req_i;
`endif
          next_state = ISSUE;
        end
      end
      ISSUE:   next_state = mem_we_o ? IDLE : WAIT;
      WAIT:    if (lat_cnt == 3'd1) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign r0_gnt_o  = grant_any && !grant_sel;
  assign r1_gnt_o  = grant_any &&  grant_sel;
  assign win_we    = grant_sel ? r1_we_i    : r0_we_i;
  assign win_addr  = grant_sel ? r1_addr_i  : r0_addr_i;
  assign win_wdata = grant_sel ? r1_wdata_i : r0_wdata_i;
  assign rd_done   = (state == WAIT) && (lat_cnt == 3'd1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Datapath: the grant cycle latches the winner's command straight into the
  // memory-side registers, so the strobes are high exactly in ISSUE while the
  // address and write data simply hold until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_re_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      owner       <= 1'b0;
      lat_cnt     <= 3'd0;
      r0_rvalid_o <= 1'b0;
      r1_rvalid_o <= 1'b0;
      r0_rdata_o  <= '0;
      r1_rdata_o  <= '0;
    end else begin
      mem_re_o <= grant_any && !win_we;
      mem_we_o <= grant_any &&  win_we;
      if (grant_any) begin
        mem_addr_o  <= win_addr;
        mem_wdata_o <= win_wdata;
        owner       <= grant_sel;
      end
      if (state == ISSUE) begin
        lat_cnt <= LAT_INIT;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
      r0_rvalid_o <= rd_done && !owner;
      r1_rvalid_o <= rd_done &&  owner;
      if (rd_done && !owner) r0_rdata_o <= mem_rdata_i;
      if (rd_done &&  owner) r1_rdata_o <= mem_rdata_i;
    end
  end

`ifndef DMEM_ARB_FIXED_PRIO_EN
  // Round-robin history; reset to r1 so that r0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner <= 1'b1;
    end else if (grant_any) begin
      last_winner <= grant_sel;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter. Instance A uses RD_LAT=1, instance B uses
// RD_LAT=3. A small memory model returns read data only in the exact cycle it
// is due (a poison value otherwise), so latency slips show up as bad data.
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  localparam logic [31:0] POISON = 32'h0BAD0BAD;

  // Instance A (RD_LAT = 1)
  logic        a_r0_req, a_r0_we, a_r0_gnt, a_r0_rvalid;
  logic [31:0] a_r0_addr, a_r0_wdata, a_r0_rdata;
  logic        a_r1_req, a_r1_we, a_r1_gnt, a_r1_rvalid;
  logic [31:0] a_r1_addr, a_r1_wdata, a_r1_rdata;
  logic        a_mem_re, a_mem_we;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  // Instance B (RD_LAT = 3)
  logic        b_r0_req, b_r0_we, b_r0_gnt, b_r0_rvalid;
  logic [31:0] b_r0_addr, b_r0_wdata, b_r0_rdata;
  logic        b_r1_req, b_r1_we, b_r1_gnt, b_r1_rvalid;
  logic [31:0] b_r1_addr, b_r1_wdata, b_r1_rdata;
  logic        b_mem_re, b_mem_we;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  int vectors     = 0;
  int miscompares = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .r0_req_i(a_r0_req), .r0_we_i(a_r0_we), .r0_addr_i(a_r0_addr), .r0_wdata_i(a_r0_wdata),
    .r0_gnt_o(a_r0_gnt), .r0_rvalid_o(a_r0_rvalid), .r0_rdata_o(a_r0_rdata),
    .r1_req_i(a_r1_req), .r1_we_i(a_r1_we), .r1_addr_i(a_r1_addr), .r1_wdata_i(a_r1_wdata),
    .r1_gnt_o(a_r1_gnt), .r1_rvalid_o(a_r1_rvalid), .r1_rdata_o(a_r1_rdata),
    .mem_re_o(a_mem_re), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
    .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .r0_req_i(b_r0_req), .r0_we_i(b_r0_we), .r0_addr_i(b_r0_addr), .r0_wdata_i(b_r0_wdata),
    .r0_gnt_o(b_r0_gnt), .r0_rvalid_o(b_r0_rvalid), .r0_rdata_o(b_r0_rdata),
    .r1_req_i(b_r1_req), .r1_we_i(b_r1_we), .r1_addr_i(b_r1_addr), .r1_wdata_i(b_r1_wdata),
    .r1_gnt_o(b_r1_gnt), .r1_rvalid_o(b_r1_rvalid), .r1_rdata_o(b_r1_rdata),
    .mem_re_o(b_mem_re), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
    .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata)
  );

  // Memory model: instance A may write; both read. Read data appears only in
  // the cycle RD_LAT cycles after the strobe.
  logic [31:0] mem [256];
  logic        a_pv = 1'b0;
  logic [31:0] a_pd = '0;
  logic [2:0]  b_pv = 3'b000;
  logic [31:0] b_pd [3];

  always @(posedge clk) begin
    if (a_mem_we) mem[a_mem_addr[7:0]] = a_mem_wdata;
    a_pv <= a_mem_re;
    a_pd <= mem[a_mem_addr[7:0]];
  end

  always @(posedge clk) begin
    b_pv    <= {b_pv[1:0], b_mem_re};
    b_pd[0] <= mem[b_mem_addr[7:0]];
    b_pd[1] <= b_pd[0];
    b_pd[2] <= b_pd[1];
  end

  assign a_mem_rdata = a_pv    ? a_pd    : POISON;
  assign b_mem_rdata = b_pv[2] ? b_pd[2] : POISON;

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  int g_seq[$];
  int g_cyc[$];
  int cyc;
  int exp_seq[4];
  bit seen;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h30] = 32'h12345678;
    b_pd[0] = '0; b_pd[1] = '0; b_pd[2] = '0;

    {a_r0_req, a_r0_we, a_r1_req, a_r1_we} = '0;
    {b_r0_req, b_r0_we, b_r1_req, b_r1_we} = '0;
    a_r0_addr = 32'h10; a_r0_wdata = '0; a_r1_addr = '0; a_r1_wdata = '0;
    b_r0_addr = '0; b_r0_wdata = '0; b_r1_addr = '0; b_r1_wdata = '0;
    a_r0_req = 1'b1;

    // Reset: a pending request must not be granted while in reset.
    repeat (2) @(posedge clk);
    sample;
    check_output("rst_a_r0_gnt", a_r0_gnt, 0);
    check_output("rst_a_mem_re", a_mem_re, 0);
    check_output("rst_a_r0_rdata", a_r0_rdata, 0);
    check_output("rst_b_mem_addr", b_mem_addr, 0);

    // r0 read 0x10, RD_LAT=1.
    tick; rst_n = 1'b1;
    sample;
    check_output("rd_c0_r0_gnt", a_r0_gnt, 1);
    check_output("rd_c0_r1_gnt", a_r1_gnt, 0);
    tick; a_r0_req = 1'b0;
    sample;
    check_output("rd_c1_mem_re", a_mem_re, 1);
    check_output("rd_c1_mem_we", a_mem_we, 0);
    check_output("rd_c1_mem_addr", a_mem_addr, 32'h10);
    check_output("rd_c1_r0_gnt", a_r0_gnt, 0);
    tick; sample;
    check_output("rd_c2_r0_rvalid", a_r0_rvalid, 0);
    check_output("rd_c2_mem_re", a_mem_re, 0);
    tick; sample;
    check_output("rd_c3_r0_rvalid", a_r0_rvalid, 1);
    check_output("rd_c3_r0_rdata", a_r0_rdata, 32'hDEADBEEF);
    check_output("rd_c3_r1_rvalid", a_r1_rvalid, 0);
    check_output("rd_c3_r1_rdata", a_r1_rdata, 0);
    tick; sample;
    check_output("rd_c4_r0_rvalid", a_r0_rvalid, 0);
    check_output("rd_c4_r0_rdata_hold", a_r0_rdata, 32'hDEADBEEF);

    // r1 write 0x20 <= 0xCAFE0001, then r0 reads it back.
    tick;
    a_r1_req = 1'b1; a_r1_we = 1'b1; a_r1_addr = 32'h20; a_r1_wdata = 32'hCAFE0001;
    sample;
    check_output("wr_c0_r1_gnt", a_r1_gnt, 1);
    check_output("wr_c0_r0_gnt", a_r0_gnt, 0);
    tick; a_r1_req = 1'b0;
    sample;
    check_output("wr_c1_mem_we", a_mem_we, 1);
    check_output("wr_c1_mem_re", a_mem_re, 0);
    check_output("wr_c1_mem_addr", a_mem_addr, 32'h20);
    check_output("wr_c1_mem_wdata", a_mem_wdata, 32'hCAFE0001);
    tick;
    a_r0_req = 1'b1; a_r0_we = 1'b0; a_r0_addr = 32'h20;
    sample;
    check_output("wr_c2_r0_gnt", a_r0_gnt, 1);
    check_output("wr_c2_mem_we", a_mem_we, 0);
    check_output("wr_c2_r1_rvalid", a_r1_rvalid, 0);
    tick; a_r0_req = 1'b0;
    sample;
    check_output("wr_c3_mem_addr", a_mem_addr, 32'h20);
    check_output("wr_c3_r1_rvalid", a_r1_rvalid, 0);
    tick; sample;
    tick; sample;
    check_output("wr_rb_r0_rvalid", a_r0_rvalid, 1);
    check_output("wr_rb_r0_rdata", a_r0_rdata, 32'hCAFE0001);

    // Contention from reset: both request writes continuously.
    tick; rst_n = 1'b0;
    tick; rst_n = 1'b1;
    a_r0_req = 1'b1; a_r0_we = 1'b1; a_r0_addr = 32'h80; a_r0_wdata = 32'h1;
    a_r1_req = 1'b1; a_r1_we = 1'b1; a_r1_addr = 32'h84; a_r1_wdata = 32'h2;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    cyc = 0;
    while (g_seq.size() < 4 && cyc < 40) begin
      sample;
      check_output("cont_gnt_onehot", a_r0_gnt & a_r1_gnt, 0);
      if (a_r0_gnt) begin g_seq.push_back(0); g_cyc.push_back(cyc); end
      else if (a_r1_gnt) begin g_seq.push_back(1); g_cyc.push_back(cyc); end
      tick; cyc++;
    end
    check_output("cont_grant_count", g_seq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < g_seq.size()) begin
        check_output($sformatf("cont_winner_%0d", i), g_seq[i], exp_seq[i]);
        check_output($sformatf("cont_cycle_%0d", i), g_cyc[i], 2 * i);
      end
    end
    a_r0_req = 1'b0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      sample;
      if (a_r0_gnt || a_r1_gnt) begin
        seen = 1'b1;
        check_output("cont_after_drop_r1_gnt", a_r1_gnt, 1);
        check_output("cont_after_drop_cycle", cyc, 8);
      end
      tick; cyc++;
    end
    check_output("cont_after_drop_seen", seen, 1);
    a_r1_req = 1'b0;

    // RD_LAT=3 on instance B: r1 request raised during WAIT.
    tick;
    b_r0_req = 1'b1; b_r0_we = 1'b0; b_r0_addr = 32'h30;
    sample;
    check_output("lat3_c0_r0_gnt", b_r0_gnt, 1);
    tick; b_r0_req = 1'b0;
    sample;
    check_output("lat3_c1_mem_re", b_mem_re, 1);
    tick;
    b_r1_req = 1'b1; b_r1_we = 1'b1; b_r1_addr = 32'h40; b_r1_wdata = 32'h5;
    sample;
    check_output("lat3_c2_r1_gnt", b_r1_gnt, 0);
    for (int c = 3; c <= 4; c++) begin
      tick; sample;
      check_output($sformatf("lat3_c%0d_r1_gnt", c), b_r1_gnt, 0);
      check_output($sformatf("lat3_c%0d_r0_rvalid", c), b_r0_rvalid, 0);
    end
    tick; sample;
    check_output("lat3_c5_r0_rvalid", b_r0_rvalid, 1);
    check_output("lat3_c5_r0_rdata", b_r0_rdata, 32'h12345678);
    check_output("lat3_c5_r1_gnt", b_r1_gnt, 1);
    tick; b_r1_req = 1'b0;
    sample;
    check_output("lat3_c6_r0_rvalid", b_r0_rvalid, 0);
    check_output("lat3_c6_mem_we", b_mem_we, 1);
    check_output("lat3_c6_mem_addr", b_mem_addr, 32'h40);

    // Reset asserted during WAIT of an r1 read on instance B.
    tick;
    b_r1_req = 1'b1; b_r1_we = 1'b0; b_r1_addr = 32'h30;
    sample;
    check_output("rstw_c0_r1_gnt", b_r1_gnt, 1);
    tick; b_r1_req = 1'b0;
    sample;
    check_output("rstw_c1_mem_re", b_mem_re, 1);
    tick; sample;
    #2;
    rst_n = 1'b0;
    b_r0_req = 1'b1; b_r0_we = 1'b1; b_r0_addr = 32'h44;
    b_r1_req = 1'b1; b_r1_we = 1'b1; b_r1_addr = 32'h48;
    #1;
    check_output("rstw_async_mem_addr", b_mem_addr, 0);
    check_output("rstw_async_mem_re", b_mem_re, 0);
    check_output("rstw_async_r0_gnt", b_r0_gnt, 0);
    check_output("rstw_async_r1_gnt", b_r1_gnt, 0);
    for (int c = 0; c < 3; c++) begin
      tick; sample;
      check_output("rstw_hold_r1_rvalid", b_r1_rvalid, 0);
      check_output("rstw_hold_mem_we", b_mem_we, 0);
    end
    tick; rst_n = 1'b1;
    sample;
    check_output("rstw_first_r0_gnt", b_r0_gnt, 1);
    check_output("rstw_first_r1_gnt", b_r1_gnt, 0);
    tick; b_r0_req = 1'b0; b_r1_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      sample;
      check_output("rstw_after_r1_rvalid", b_r1_rvalid, 0);
      tick;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
